// File: rtl/pe_result_packer.sv
// pe_result_packer
//   Packs the 64-bit results of the type-B processing element into wide
//   AXI4-Stream beats. One beat is assembled while the previous one waits in
//   the output register, so the PE can run at full rate while the sink
//   accepts one beat per cycle.
//
//   Optional feature: define PE_PACK_FLUSH_EN to add the flush input, which
//   closes a partially filled beat (unused lanes zero, tkeep only on filled
//   lanes, tlast forced high). Without it only full beats are produced.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   in_data        PE result word
//   in_valid       in_data valid
//   in_ready       packer accepts in_data this cycle (registered)
//   m_axis_tdata   packed beat, lane 0 = bits [DATA_W-1:0]
//   m_axis_tkeep   byte enables
//   m_axis_tvalid  beat valid
//   m_axis_tready  sink accepts beat
//   m_axis_tlast   last beat of packet
//   flush          (PE_PACK_FLUSH_EN only) close the partial beat
module pe_result_packer #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned LANES     = 8,
  parameter int unsigned PKT_BEATS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W*LANES-1:0]    m_axis_tdata,
  output logic [DATA_W*LANES/8-1:0]  m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast
`ifdef PE_PACK_FLUSH_EN
  ,
  input  logic                       flush
`endif
);

  localparam int unsigned BEAT_W      = DATA_W * LANES;
  localparam int unsigned KEEP_W      = BEAT_W / 8;
  localparam int unsigned LANE_KEEP_W = DATA_W / 8;
  localparam int unsigned LANE_CW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned FILL_CW     = LANE_CW + 1;
  localparam int unsigned BEAT_CW     = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state;
  logic [LANE_CW-1:0]   lane_cnt;
  logic [BEAT_CW-1:0]   beat_cnt;
  logic [BEAT_W-1:0]    asm_data;
  logic [KEEP_W-1:0]    hold_keep;
  logic                 hold_flush;

  logic                 flush_req;
  logic                 accept;
  logic                 close_full;
  logic                 close_flush;
  logic                 close_beat;
  logic                 out_free;
  logic                 out_fire;
  logic [BEAT_CW-1:0]   beat_cnt_next;
  logic                 next_is_last;
  logic [FILL_CW-1:0]   fill_cnt;
  logic [BEAT_W-1:0]    merged_data;
  logic [KEEP_W-1:0]    merged_keep;

`ifdef PE_PACK_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Handshake and beat-closing conditions
  assign accept      = in_valid && in_ready;
  assign close_full  = accept && (lane_cnt == LANE_CW'(LANES - 1));
  // A word accepted in the same cycle as flush belongs to the flushed beat
  assign close_flush = flush_req && (state == FILL) &&
                       ((lane_cnt != LANE_CW'(0)) || accept);
  assign close_beat  = close_full || close_flush;
  assign out_fire    = m_axis_tvalid && m_axis_tready;
  assign out_free    = !m_axis_tvalid || m_axis_tready;

  // Packet position of whatever beat sits in the output register after this
  // edge; a beat loaded now gets exactly this index, which makes tlast a
  // registered function of the beat it travels with.
  always_comb begin
    beat_cnt_next = beat_cnt;
    if (out_fire) begin
      if (m_axis_tlast) begin
        beat_cnt_next = BEAT_CW'(0);
      end else begin
        beat_cnt_next = beat_cnt + BEAT_CW'(1);
      end
    end
  end

  assign next_is_last = (beat_cnt_next == BEAT_CW'(PKT_BEATS - 1));

  // Assembly contents including the word accepted this cycle
  assign fill_cnt = FILL_CW'(lane_cnt) + FILL_CW'(accept);

  always_comb begin
    merged_data = asm_data;
    merged_keep = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (accept && (lane_cnt == LANE_CW'(i))) begin
        merged_data[i*DATA_W +: DATA_W] = in_data;
      end
      if (FILL_CW'(i) < fill_cnt) begin
        merged_keep[i*LANE_KEEP_W +: LANE_KEEP_W] = '1;
      end
    end
  end

  // Packer FSM, counters, assembly and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= FILL;
      in_ready      <= 1'b0;
      lane_cnt      <= '0;
      beat_cnt      <= '0;
      asm_data      <= '0;
      hold_keep     <= '0;
      hold_flush    <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      beat_cnt <= beat_cnt_next;
      if (out_fire) begin
        m_axis_tvalid <= 1'b0;
      end

      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (close_beat) begin
            lane_cnt <= '0;
            if (out_free) begin
              // Output slot empty or draining: hand the beat over directly
              m_axis_tdata  <= merged_data;
              m_axis_tkeep  <= merged_keep;
              m_axis_tlast  <= next_is_last || close_flush;
              m_axis_tvalid <= 1'b1;
              // Cleared so a later partial beat never shows stale lanes
              asm_data      <= '0;
            end else begin
              asm_data   <= merged_data;
              hold_keep  <= merged_keep;
              hold_flush <= close_flush;
              in_ready   <= 1'b0;
              state      <= HOLD;
            end
          end else if (accept) begin
            asm_data <= merged_data;
            lane_cnt <= lane_cnt + LANE_CW'(1);
          end
        end

        HOLD: begin
          if (out_fire) begin
            m_axis_tdata  <= asm_data;
            m_axis_tkeep  <= hold_keep;
            m_axis_tlast  <= next_is_last || hold_flush;
            m_axis_tvalid <= 1'b1;
            asm_data      <= '0;
            hold_flush    <= 1'b0;
            in_ready      <= 1'b1;
            state         <= FILL;
          end else begin
            in_ready <= 1'b0;
          end
        end

        default: begin
          state    <= FILL;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_result_packer.sv
// Self-checking bench for pe_result_packer: a word-level model builds the
// expected beats as words are sent, and a monitor compares the output beat
// against the front of the expected queue every cycle it is valid.
module tb_pe_result_packer;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned LANES     = 8;
  localparam int unsigned PKT_BEATS = 16;
  localparam int unsigned BEAT_W    = DATA_W * LANES;
  localparam int unsigned KEEP_W    = BEAT_W / 8;

  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [BEAT_W-1:0] m_axis_tdata;
  logic [KEEP_W-1:0] m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic              m_axis_tlast;
`ifdef PE_PACK_FLUSH_EN
  logic              flush = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int stalls = 0;
  int unexpected = 0;
  int lasts_seen = 0;

  beat_t             exp_q[$];
  logic [BEAT_W-1:0] m_data = '0;
  int                m_lane = 0;
  int                m_beat = 0;

  pe_result_packer #(
    .DATA_W   (DATA_W),
    .LANES    (LANES),
    .PKT_BEATS(PKT_BEATS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast)
`ifdef PE_PACK_FLUSH_EN
    ,
    .flush        (flush)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [BEAT_W-1:0] act,
                       input logic [BEAT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model of beat assembly and packet position
  task automatic model_push(input logic [DATA_W-1:0] w);
    beat_t b;
    m_data[m_lane*DATA_W +: DATA_W] = w;
    m_lane++;
    if (m_lane == int'(LANES)) begin
      b.data = m_data;
      b.keep = '1;
      b.last = (m_beat == int'(PKT_BEATS) - 1);
      exp_q.push_back(b);
      m_beat = (m_beat == int'(PKT_BEATS) - 1) ? 0 : m_beat + 1;
      m_data = '0;
      m_lane = 0;
    end
  endtask

  task automatic model_flush();
    beat_t b;
    if (m_lane > 0) begin
      b.data = m_data;
      b.keep = '0;
      for (int i = 0; i < m_lane; i++) b.keep[i*(DATA_W/8) +: DATA_W/8] = '1;
      b.last = 1'b1;
      exp_q.push_back(b);
      m_beat = 0;
      m_data = '0;
      m_lane = 0;
    end
  endtask

  task automatic model_reset();
    m_data = '0;
    m_lane = 0;
    m_beat = 0;
    exp_q.delete();
  endtask

  // Output monitor: sampled on the falling edge, clear of the active edge
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid) begin
      if (exp_q.size() == 0) begin
        unexpected++;
      end else begin
        check("tdata", m_axis_tdata, exp_q[0].data);
        check("tkeep", BEAT_W'(m_axis_tkeep), BEAT_W'(exp_q[0].keep));
        check("tlast", BEAT_W'(m_axis_tlast), BEAT_W'(exp_q[0].last));
        if (m_axis_tready) begin
          if (m_axis_tlast) lasts_seen++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Present one word; leaves in_valid high so words can go back-to-back
  task automatic send_word(input logic [DATA_W-1:0] w);
    int n;
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (n >= 50) check("rdy_wait", BEAT_W'(in_ready), BEAT_W'(1));
    @(posedge clk);
    if (in_ready) model_push(w);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, BEAT_W'(exp_q.size()), BEAT_W'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int l0;
    // 1: reset values, then ready after release
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", BEAT_W'(m_axis_tvalid), BEAT_W'(0));
    check("rst_tlast", BEAT_W'(m_axis_tlast), BEAT_W'(0));
    check("rst_tdata", m_axis_tdata, BEAT_W'(0));
    check("rst_tkeep", BEAT_W'(m_axis_tkeep), BEAT_W'(0));
    check("rst_in_ready", BEAT_W'(in_ready), BEAT_W'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", BEAT_W'(in_ready), BEAT_W'(1));

    // 2: one full beat, latency of one cycle after the eighth word
    m_axis_tready = 1'b1;
    stalls = 0;
    for (int i = 1; i <= 8; i++) begin
      send_word(DATA_W'(i));
      if (i == 7) check("t2_tvalid_early", BEAT_W'(m_axis_tvalid), BEAT_W'(0));
    end
    check("t2_tvalid_latency", BEAT_W'(m_axis_tvalid), BEAT_W'(1));
    idle();
    wait_drain("t2_drain");
    check("t2_stalls", BEAT_W'(stalls), BEAT_W'(0));

    // 3: 17 beats at full rate, tlast only on the sixteenth
    do_reset();
    m_axis_tready = 1'b1;
    stalls = 0;
    l0 = lasts_seen;
    for (int i = 0; i < 136; i++) send_word(DATA_W'(64'h1000 + i));
    idle();
    wait_drain("t3_drain");
    check("t3_stalls", BEAT_W'(stalls), BEAT_W'(0));
    check("t3_tlast_count", BEAT_W'(lasts_seen - l0), BEAT_W'(1));

    // 4: sink stalled, second beat held, then both drain in order
    m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) send_word({$urandom, $urandom});
    idle();
    check("t4_hold_in_ready", BEAT_W'(in_ready), BEAT_W'(0));
    repeat (3) @(posedge clk);
    #1;
    check("t4_hold_in_ready_late", BEAT_W'(in_ready), BEAT_W'(0));
    check("t4_hold_tvalid", BEAT_W'(m_axis_tvalid), BEAT_W'(1));
    check("t4_queued", BEAT_W'(exp_q.size()), BEAT_W'(2));
    m_axis_tready = 1'b1;
    for (int n = 0; n < 10 && !in_ready; n++) begin
      @(posedge clk);
      #1;
    end
    check("t4_in_ready_back", BEAT_W'(in_ready), BEAT_W'(1));
    wait_drain("t4_drain");

    // 5: reset mid-beat discards the partial words
    for (int i = 0; i < 5; i++) send_word(DATA_W'(64'hDEAD_0000 + i));
    idle();
    rst = 1'b1;
    model_reset();
    #1;
    check("t5_rst_tvalid", BEAT_W'(m_axis_tvalid), BEAT_W'(0));
    check("t5_rst_tdata", m_axis_tdata, BEAT_W'(0));
    check("t5_rst_in_ready", BEAT_W'(in_ready), BEAT_W'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) send_word(64'h4010_0000_0000_0000);
    idle();
    wait_drain("t5_drain");

`ifdef PE_PACK_FLUSH_EN
    // 6: partial beat closed by flush, then a normal beat starts a new packet
    send_word(64'hA);
    send_word(64'hB);
    send_word(64'hC);
    idle();
    flush = 1'b1;
    @(posedge clk);
    model_flush();
    #1 flush = 1'b0;
    check("t6_flush_tvalid", BEAT_W'(m_axis_tvalid), BEAT_W'(1));
    check("t6_flush_tkeep", BEAT_W'(m_axis_tkeep), BEAT_W'(64'h0000_0000_00FF_FFFF));
    wait_drain("t6_flush_drain");
    for (int i = 0; i < 8; i++) send_word(DATA_W'(64'h600 + i));
    idle();
    wait_drain("t6_next_drain");
`endif

    check("unexpected_beats", BEAT_W'(unexpected), BEAT_W'(0));
    check("queue_empty", BEAT_W'(exp_q.size()), BEAT_W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
